// File: rtl/ahb_slave_responder_if.sv
// AHB slave-port bundle between the decoder/mux fabric and one responder.
interface ahb_slave_responder_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [2:0]        hsize;
    logic              hwrite;
    logic [DATA_W-1:0] hwdata;
    logic              hready_in;
    logic              hreadyout;
    logic [1:0]        hresp;
    logic [DATA_W-1:0] hrdata;
    logic              hlast_slv;

    modport master (
        output hsel, haddr, htrans, hsize, hwrite, hwdata, hready_in,
        input  hreadyout, hresp, hrdata, hlast_slv
    );

    modport slave (
        input  hsel, haddr, htrans, hsize, hwrite, hwdata, hready_in,
        output hreadyout, hresp, hrdata, hlast_slv
    );
endinterface

// File: rtl/ahb_slave_responder.sv
// AHB memory responder with programmable wait states behind the address decoder.
// Optional two-cycle ERROR response for illegal accesses: define AHB_SLV_ERROR_RESP_EN.
module ahb_slave_responder #(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH      = 256,
    parameter int unsigned WAIT_CYCLES    = 1
) (
    input logic                  hclk,
    input logic                  hreset,
    ahb_slave_responder_if.slave bus
);
    localparam int unsigned OFF_W  = $clog2(MEM_DEPTH * 4);
    localparam int unsigned IDX_W  = OFF_W - 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SIZE_W = 3;

    localparam logic [OFF_W:0]       REGION_BYTES = (OFF_W + 1)'(MEM_DEPTH * 4);
    localparam logic [IDX_W-1:0]     LAST_IDX     = IDX_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]     CNT_LOAD     = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    localparam logic [1:0]        HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]        HTRANS_SEQ    = 2'b11;
    localparam logic [SIZE_W-1:0] SIZE_BYTE     = 3'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF     = 3'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD     = 3'd2;
    localparam logic [1:0]        HRESP_OKAY    = 2'b00;
`ifdef AHB_SLV_ERROR_RESP_EN
    localparam logic [1:0]        HRESP_ERROR   = 2'b01;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA
`ifdef AHB_SLV_ERROR_RESP_EN
        ,
        S_ERR1,
        S_ERR2
`endif
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [OFF_W-1:0]          off_q, off_d;
    logic [SIZE_W-1:0]         size_q, size_d;
    logic                      write_q, write_d;
    logic                      legal_q, legal_d;
    logic                      hreadyout_q, hreadyout_d;
    logic [1:0]                hresp_q, hresp_d;
    logic [AHB_DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic                      hlast_q, hlast_d;

    logic [AHB_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic [OFF_W-1:0]          off_c;
    logic                      in_range_c;
    logic                      legal_c;
    logic                      accept_c;
    logic                      take_c;
    logic                      mem_we_c;
    logic [IDX_W-1:0]          wr_idx_c;
    logic [AHB_DATA_WIDTH-1:0] wr_mask_c;
    logic [AHB_DATA_WIDTH-1:0] wr_word_c;
    logic [IDX_W-1:0]          rd_idx_c;
    logic [AHB_DATA_WIDTH-1:0] rd_word_c;
    logic                      unused_addr;

    assign unused_addr = ^bus.haddr[AHB_ADDR_WIDTH-1:OFF_W];

    // Little-endian byte-lane enables for a transfer of the given size/offset.
    function automatic logic [AHB_DATA_WIDTH-1:0] lane_mask(input logic [SIZE_W-1:0] size,
                                                            input logic [1:0]        lo);
        logic [AHB_DATA_WIDTH-1:0] m;
        case (size)
            SIZE_BYTE: m = AHB_DATA_WIDTH'(32'h0000_00FF) << {lo, 3'b000};
            SIZE_HALF: m = AHB_DATA_WIDTH'(32'h0000_FFFF) << {lo[1], 4'b0000};
            default:   m = '1;
        endcase
        return m;
    endfunction

    // Address-phase decode: acceptance and legality of the transfer on the bus.
    always_comb begin
        off_c      = bus.haddr[OFF_W-1:0];
        accept_c   = bus.hsel & bus.hready_in &
                     ((bus.htrans == HTRANS_NONSEQ) | (bus.htrans == HTRANS_SEQ));
        in_range_c = ({1'b0, off_c} < REGION_BYTES);
        legal_c    = in_range_c &
                     ((bus.hsize == SIZE_BYTE) |
                      ((bus.hsize == SIZE_HALF) & ~off_c[0]) |
                      ((bus.hsize == SIZE_WORD) & (off_c[1:0] == 2'b00)));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        size_d      = size_q;
        write_d     = write_q;
        legal_d     = legal_q;
        hrdata_d    = hrdata_q;
        hlast_d     = 1'b0;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        take_c      = 1'b0;
        mem_we_c    = 1'b0;
        wr_idx_c    = off_q[OFF_W-1:2];
        wr_mask_c   = lane_mask(size_q, off_q[1:0]);
        wr_word_c   = (mem_q[wr_idx_c] & ~wr_mask_c) | (bus.hwdata & wr_mask_c);
        rd_idx_c    = '0;
        rd_word_c   = '0;

        case (state_q)
            S_IDLE: take_c = accept_c;
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                mem_we_c = write_q & legal_q;
                take_c   = accept_c;
                state_d  = S_IDLE;
            end
`ifdef AHB_SLV_ERROR_RESP_EN
            S_ERR1: state_d = S_ERR2;
            S_ERR2: begin
                take_c  = accept_c;
                state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (take_c) begin
            off_d   = off_c;
            size_d  = bus.hsize;
            write_d = bus.hwrite;
            legal_d = legal_c;
            hlast_d = in_range_c & (off_c[OFF_W-1:2] == LAST_IDX);
`ifdef AHB_SLV_ERROR_RESP_EN
            if (!legal_c) begin
                state_d = S_ERR1;
            end else
`endif
            if (WAIT_CYCLES > 0) begin
                state_d = S_WAIT;
                cnt_d   = CNT_LOAD;
            end else begin
                state_d = S_DATA;
            end
        end

        // Read data is captured on entry to the data phase; a write retiring in the
        // same cycle to the same word is merged in so back-to-back RAW sees new data.
        rd_idx_c  = off_d[OFF_W-1:2];
        rd_word_c = mem_q[rd_idx_c];
        if (mem_we_c && (rd_idx_c == wr_idx_c)) begin
            rd_word_c = wr_word_c;
        end
        if ((state_d == S_DATA) && (take_c || (state_q == S_WAIT)) && !write_d) begin
            hrdata_d = legal_d ? rd_word_c : '0;
        end

        if (state_d == S_WAIT) begin
            hreadyout_d = 1'b0;
        end
`ifdef AHB_SLV_ERROR_RESP_EN
        if (state_d == S_ERR1) begin
            hreadyout_d = 1'b0;
        end
        if ((state_d == S_ERR1) || (state_d == S_ERR2)) begin
            hresp_d = HRESP_ERROR;
        end
`endif
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            size_q      <= '0;
            write_q     <= 1'b0;
            legal_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            hlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            size_q      <= size_d;
            write_q     <= write_d;
            legal_q     <= legal_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            hlast_q     <= hlast_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge hclk) begin
        if (mem_we_c) begin
            mem_q[wr_idx_c] <= wr_word_c;
        end
    end

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;
    assign bus.hlast_slv = hlast_q;

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Bench for ahb_slave_responder: WAIT_CYCLES=0 vector table plus WAIT_CYCLES=1 directed and random tests.
module tb_ahb_slave_responder;
    localparam int unsigned WAIT_A = 1;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] Z_B = 3'd0, Z_H = 3'd1, Z_W = 3'd2;
`ifdef AHB_SLV_ERROR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic hclk = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    ahb_slave_responder_if a_if ();
    ahb_slave_responder_if b_if ();
    assign a_if.hready_in = a_if.hreadyout;
    assign b_if.hready_in = b_if.hreadyout;

    ahb_slave_responder #(.WAIT_CYCLES(WAIT_A)) dut_a (.hclk(hclk), .hreset(hreset), .bus(a_if.slave));
    ahb_slave_responder #(.WAIT_CYCLES(0))      dut_b (.hclk(hclk), .hreset(hreset), .bus(b_if.slave));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] e_rdata;
        logic        e_last;
    } vec_t;

    function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                                input logic [31:0] rd, input logic last);
        vec_t v;
        v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz; v.ad = ad; v.wd = wd;
        v.e_rdata = rd; v.e_last = last;
        return v;
    endfunction

    // One non-overlapping-start transfer on bus A; returns at the completing data-phase cycle.
    task automatic a_xfer(input logic [1:0] tr, input logic wr, input logic [31:0] ad,
                          input logic [2:0] sz, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic [1:0] resp,
                          output logic [1:0] resp1, output int waits, output logic last);
        a_if.hsel = 1'b1; a_if.htrans = tr; a_if.haddr = ad; a_if.hsize = sz; a_if.hwrite = wr;
        @(posedge hclk); #1;
        a_if.hsel = 1'b0; a_if.htrans = T_IDLE; a_if.hwdata = wd;
        last  = a_if.hlast_slv;
        resp1 = a_if.hresp;
        waits = 0;
        while (a_if.hreadyout !== 1'b1 && waits < 40) begin
            waits++;
            @(posedge hclk); #1;
        end
        rdata = a_if.hrdata;
        resp  = a_if.hresp;
    endtask

    vec_t        vecs [16];
    logic [31:0] model [256];
    int          pool [12] = '{0, 1, 2, 3, 4, 5, 250, 251, 252, 253, 254, 255};
    logic [31:0] rd, hold, ad, wd, m, er;
    logic [1:0]  rs, rs1, bb;
    logic [2:0]  sz;
    logic        lst, wr, ill;
    int          wt, w, s;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        a_if.hsel = 0; a_if.htrans = T_IDLE; a_if.haddr = 0; a_if.hsize = Z_W; a_if.hwrite = 0; a_if.hwdata = 0;
        b_if.hsel = 0; b_if.htrans = T_IDLE; b_if.haddr = 0; b_if.hsize = Z_W; b_if.hwrite = 0; b_if.hwdata = 0;
        repeat (3) @(posedge hclk);
        #1;
        check("rst_a_rdy",   32'(a_if.hreadyout), 32'd1);
        check("rst_a_resp",  32'(a_if.hresp),     32'd0);
        check("rst_a_rdata", a_if.hrdata,         32'd0);
        check("rst_a_last",  32'(a_if.hlast_slv), 32'd0);
        check("rst_b_rdata", b_if.hrdata,         32'd0);
        hreset = 0;
        @(posedge hclk); #1;

        // WAIT_CYCLES=0 pipelined vectors: hwdata in row i belongs to the write accepted in row i-1.
        vecs[0]  = mk(1, T_NSEQ, 1, Z_W, 32'h040, 32'h0,        32'h0,        0);
        vecs[1]  = mk(1, T_NSEQ, 0, Z_W, 32'h040, 32'hCAFEF00D, 32'hCAFEF00D, 0);
        vecs[2]  = mk(1, T_IDLE, 0, Z_W, 32'h040, 32'h0,        32'hCAFEF00D, 0);
        vecs[3]  = mk(1, T_NSEQ, 1, Z_W, 32'h044, 32'h0,        32'hCAFEF00D, 0);
        vecs[4]  = mk(1, T_BUSY, 0, Z_W, 32'h048, 32'h11111111, 32'hCAFEF00D, 0);
        vecs[5]  = mk(1, T_SEQ,  0, Z_W, 32'h044, 32'h0,        32'h11111111, 0);
        vecs[6]  = mk(1, T_NSEQ, 1, Z_W, 32'h3FC, 32'h0,        32'h11111111, 1);
        vecs[7]  = mk(1, T_NSEQ, 0, Z_H, 32'h042, 32'h55667788, 32'hCAFEF00D, 0);
        vecs[8]  = mk(1, T_NSEQ, 0, Z_W, 32'h3FC, 32'h0,        32'h55667788, 1);
        vecs[9]  = mk(0, T_NSEQ, 1, Z_W, 32'h040, 32'h0,        32'h55667788, 0);
        vecs[10] = mk(1, T_NSEQ, 0, Z_W, 32'h040, 32'hFFFFFFFF, 32'hCAFEF00D, 0);
        vecs[11] = mk(1, T_NSEQ, 1, Z_B, 32'h041, 32'h0,        32'hCAFEF00D, 0);
        vecs[12] = mk(1, T_NSEQ, 0, Z_W, 32'h040, 32'h00007700, 32'hCAFE770D, 0);
        vecs[13] = mk(1, T_IDLE, 1, Z_W, 32'h040, 32'h0,        32'hCAFE770D, 0);
        vecs[14] = mk(1, T_NSEQ, 0, Z_H, 32'h046, 32'h0,        32'h11111111, 0);
        vecs[15] = mk(0, T_IDLE, 0, Z_W, 32'h000, 32'h0,        32'h11111111, 0);
        for (int i = 0; i < 16; i++) begin
            b_if.hsel = vecs[i].sel; b_if.htrans = vecs[i].tr; b_if.hwrite = vecs[i].wr;
            b_if.hsize = vecs[i].sz; b_if.haddr = vecs[i].ad; b_if.hwdata = vecs[i].wd;
            @(posedge hclk); #1;
            check($sformatf("vec%0d_rdy", i),   32'(b_if.hreadyout), 32'd1);
            check($sformatf("vec%0d_resp", i),  32'(b_if.hresp),     32'd0);
            check($sformatf("vec%0d_rdata", i), b_if.hrdata,         vecs[i].e_rdata);
            check($sformatf("vec%0d_last", i),  32'(b_if.hlast_slv), 32'(vecs[i].e_last));
        end
        b_if.hsel = 0; b_if.htrans = T_IDLE;

        // Word write then read with one wait state each.
        a_xfer(T_NSEQ, 1, 32'h10, Z_W, 32'hDEADBEEF, rd, rs, rs1, wt, lst);
        check("wr10_waits", 32'(wt), 32'(WAIT_A));
        check("wr10_resp1", 32'(rs1), 32'd0);
        check("wr10_resp",  32'(rs), 32'd0);
        a_xfer(T_NSEQ, 0, 32'h10, Z_W, 32'h0, rd, rs, rs1, wt, lst);
        check("rd10_waits", 32'(wt), 32'(WAIT_A));
        check("rd10_data",  rd, 32'hDEADBEEF);
        check("rd10_resp",  32'(rs), 32'd0);

        // Byte lane merge.
        a_xfer(T_NSEQ, 1, 32'h20, Z_W, 32'h11223344, rd, rs, rs1, wt, lst);
        a_xfer(T_NSEQ, 1, 32'h21, Z_B, 32'h0000AA00, rd, rs, rs1, wt, lst);
        a_xfer(T_NSEQ, 0, 32'h20, Z_W, 32'h0, rd, rs, rs1, wt, lst);
        check("byte_merge", rd, 32'h1122AA44);

        // 4-beat INCR burst ending on the last word of the region.
        for (int k = 0; k < 4; k++) begin
            a_xfer((k == 0) ? T_NSEQ : T_SEQ, 1, 32'h3F0 + 32'(4 * k), Z_W, 32'hB0000000 + 32'(k), rd, rs, rs1, wt, lst);
            check($sformatf("bw%0d_last", k), 32'(lst), (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("bw%0d_resp", k), 32'(rs), 32'd0);
        end
        for (int k = 0; k < 4; k++) begin
            a_xfer((k == 0) ? T_NSEQ : T_SEQ, 0, 32'h3F0 + 32'(4 * k), Z_W, 32'h0, rd, rs, rs1, wt, lst);
            check($sformatf("br%0d_last", k), 32'(lst), (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("br%0d_data", k), rd, 32'hB0000000 + 32'(k));
        end

        // Misaligned word access.
        a_xfer(T_NSEQ, 1, 32'h00, Z_W, 32'h5A5A5A5A, rd, rs, rs1, wt, lst);
        hold = rd;
        a_xfer(T_NSEQ, 1, 32'h02, Z_W, 32'hFFFFFFFF, rd, rs, rs1, wt, lst);
        check("ill_wr_resp1", 32'(rs1), ERR_EN ? 32'd1 : 32'd0);
        check("ill_wr_waits", 32'(wt), ERR_EN ? 32'd1 : 32'(WAIT_A));
        check("ill_wr_resp",  32'(rs), ERR_EN ? 32'd1 : 32'd0);
        a_xfer(T_NSEQ, 0, 32'h02, Z_W, 32'h0, rd, rs, rs1, wt, lst);
        check("ill_rd_resp",  32'(rs), ERR_EN ? 32'd1 : 32'd0);
        check("ill_rd_data",  rd, ERR_EN ? hold : 32'd0);
        a_xfer(T_NSEQ, 0, 32'h00, Z_W, 32'h0, rd, rs, rs1, wt, lst);
        check("ill_mem_kept", rd, 32'h5A5A5A5A);

        // Reset while a write is stalled in its wait state.
        a_xfer(T_NSEQ, 0, 32'h10, Z_W, 32'h0, rd, rs, rs1, wt, lst);
        a_xfer(T_NSEQ, 1, 32'h14, Z_W, 32'h01020304, rd, rs, rs1, wt, lst);
        a_if.hsel = 1; a_if.htrans = T_NSEQ; a_if.haddr = 32'h14; a_if.hsize = Z_W; a_if.hwrite = 1;
        @(posedge hclk); #1;
        a_if.hsel = 0; a_if.htrans = T_IDLE; a_if.hwdata = 32'hFFFF0000;
        check("pre_rst_rdy",   32'(a_if.hreadyout), 32'd0);
        check("pre_rst_rdata", a_if.hrdata, 32'hDEADBEEF);
        hreset = 1; #1;
        check("mid_rst_rdy",   32'(a_if.hreadyout), 32'd1);
        check("mid_rst_resp",  32'(a_if.hresp), 32'd0);
        check("mid_rst_rdata", a_if.hrdata, 32'd0);
        check("mid_rst_last",  32'(a_if.hlast_slv), 32'd0);
        @(posedge hclk); #1;
        hreset = 0;
        @(posedge hclk); #1;
        a_xfer(T_NSEQ, 0, 32'h14, Z_W, 32'h0, rd, rs, rs1, wt, lst);
        check("post_rst_waits", 32'(wt), 32'(WAIT_A));
        check("post_rst_data",  rd, 32'h01020304);

        // Random traffic against a byte-lane memory model.
        for (int i = 0; i < 12; i++) begin
            wd = $urandom;
            model[pool[i]] = wd;
            a_xfer(T_NSEQ, 1, 32'(pool[i] * 4), Z_W, wd, rd, rs, rs1, wt, lst);
        end
        a_xfer(T_NSEQ, 0, 32'h0, Z_W, 32'h0, rd, rs, rs1, wt, lst);
        check("rnd_init", rd, model[0]);
        hold = rd;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) begin
                a_if.hsel = 1'($urandom_range(1));
                a_if.htrans = ($urandom_range(1) == 1) ? T_BUSY : T_IDLE;
                a_if.haddr = $urandom; a_if.hwrite = 1'($urandom_range(1));
                @(posedge hclk); #1;
                check("idle_rdy",   32'(a_if.hreadyout), 32'd1);
                check("idle_resp",  32'(a_if.hresp), 32'd0);
                check("idle_rdata", a_if.hrdata, hold);
                a_if.hsel = 0; a_if.htrans = T_IDLE;
            end
            w  = pool[$urandom_range(11)];
            s  = int'($urandom_range(9));
            sz = (s < 3) ? Z_B : (s < 6) ? Z_H : (s < 9) ? Z_W : 3'($urandom_range(7, 3));
            bb = 2'($urandom_range(3));
            if ($urandom_range(3) != 0) bb = (sz == Z_H) ? {bb[1], 1'b0} : (sz == Z_W) ? 2'b00 : bb;
            ill = (sz > Z_W) || (sz == Z_H && bb[0]) || (sz == Z_W && bb != 2'b00);
            ad = ($urandom & 32'hFFFF_FC00) | 32'(w * 4) | 32'(bb);
            wr = 1'($urandom_range(1));
            wd = $urandom;
            a_xfer(T_NSEQ, wr, ad, sz, wd, rd, rs, rs1, wt, lst);
            check("rnd_waits", 32'(wt),  (ill && ERR_EN) ? 32'd1 : 32'(WAIT_A));
            check("rnd_resp1", 32'(rs1), (ill && ERR_EN) ? 32'd1 : 32'd0);
            check("rnd_resp",  32'(rs),  (ill && ERR_EN) ? 32'd1 : 32'd0);
            check("rnd_last",  32'(lst), (w == 255) ? 32'd1 : 32'd0);
            if (wr) begin
                check("rnd_wr_hold", rd, hold);
                if (!ill) begin
                    m = (sz == Z_B) ? (32'h0000_00FF << (8 * bb)) :
                        (sz == Z_H) ? (32'h0000_FFFF << (8 * bb)) : 32'hFFFF_FFFF;
                    model[w] = (model[w] & ~m) | (wd & m);
                end
            end else begin
                er = ill ? (ERR_EN ? hold : 32'd0) : model[w];
                check("rnd_rdata", rd, er);
                hold = er;
            end
        end

        @(posedge hclk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
